mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the processor's single external memory port (A/WD/WE/RD) between two requesters:
//   port 0 = cache line refill/writeback, port 1 = debug/JTAG memory access.
//   Round-robin, one transaction in flight, fixed memory latency.
//   Lets the debug interface read and write memory while the core runs, without corrupting cache traffic.
// PARAMETERS
//   N        8  address and data width
//   MEM_LAT  2  cycles from address valid to mem_rd valid; legal values are >=1
// PORTS
//   CLK       in   1  single clock; every register updates on the rising edge
//   RESET     in   1  synchronous, active-high reset
//   r0_req    in   1  port 0 request; held high until r0_ack
//   r0_we     in   1  port 0 write (1) / read (0); stable while r0_req is high
//   r0_addr   in   N  port 0 address; stable while r0_req is high
//   r0_wd     in   N  port 0 write data; stable while r0_req is high
//   r0_rd     out  N  port 0 read data; valid in the r0_ack cycle, held until the next port 0 read
//   r0_ack    out  1  one-cycle completion pulse for port 0
//   r1_*      same six signals for port 1 (r1_req, r1_we, r1_addr, r1_wd, r1_rd, r1_ack)
//   mem_a     out  N  memory address (registered)
//   mem_wd    out  N  memory write data (registered)
//   mem_we    out  1  memory write enable (registered)
//   mem_rd    in   N  memory read data, valid MEM_LAT cycles after mem_a
//   busy      out  1  high whenever state != IDLE
//   owner     out  1  index of the port granted most recently
// BEHAVIOUR
// - Reset values: all outputs are 0. State = IDLE, lat_cnt = 0, last = 1, so port 0 wins the first tie.
// - States: IDLE -> ACCESS -> DONE -> IDLE.
// - IDLE, cycle t, at least one req high:
//   - Only one req high: grant that port.
//   - Both high: grant ~last.
//   - At the end of cycle t: latch the granted port's addr/wd/we into mem_a/mem_wd/mem_we,
//     set owner and last to the granted port, load lat_cnt = MEM_LAT-1, go to ACCESS.
// - IDLE with no req: stay in IDLE. mem_we = 0; mem_a/mem_wd keep their last values.
// - ACCESS, cycles t+1 .. t+MEM_LAT:
//   - mem_a is held stable throughout.
//   - mem_we is high only in cycle t+1, and only for a write.
//   - lat_cnt decrements each cycle. In the cycle where lat_cnt == 0:
//     - on a read, capture mem_rd into the owner's rd register;
//     - go to DONE.
// - DONE, cycle t+MEM_LAT+1:
//   - Owner's ack = 1 for exactly one cycle; the other ack stays 0.
//   - Next state is always IDLE.
//   - A req still high in DONE belongs to the finished transaction and is not sampled.
// - Latency: ack arrives MEM_LAT+1 cycles after req is sampled in IDLE.
//   Back-to-back throughput is one transaction per MEM_LAT+2 cycles.
// - Writes leave rd unchanged. The non-owner's rd and ack are never disturbed.
// - Fairness: a port waits at most one transaction of the other port.
//   With both ports always requesting, grants alternate 0,1,0,1.
// - req dropped before ack (protocol violation): the transaction still completes and ack is still pulsed.
// - RESET in any state, including mid-ACCESS: the next cycle is IDLE with all outputs 0.
//   No ack is issued for the abandoned transaction; requesters must reissue it.
// - lat_cnt width is $clog2(MEM_LAT+1) bits. MEM_LAT = 0 is illegal; flag it with an elaboration-time assertion.
// TESTING (MEM_LAT=2 unless stated)
// 1. Reset, then r0 read addr 0x10 with the memory model returning 0x5A
//    -> r0_ack at t+3, r0_rd = 0x5A, mem_we never high, r1_ack stays 0.
// 2. r1 write addr 0x22, data 0x7E
//    -> mem_we high in exactly one cycle (t+1) with mem_a = 0x22 and mem_wd = 0x7E;
//       r1_ack at t+3; r1_rd unchanged.
// 3. r0 and r1 both raised in the same cycle right after reset
//    -> r0 served first (ack at t+3); r1 granted at t+4 and acked at t+7; owner goes 0 then 1.
// 4. Both requests held continuously for 6 transactions, each reissued after its ack
//    -> grant order 0,1,0,1,0,1; ack spacing of 4 cycles.
// 5. RESET pulsed in the second ACCESS cycle of an r0 write
//    -> next cycle IDLE, mem_we = 0, busy = 0, no r0_ack; a reissued request completes normally.
// 6. MEM_LAT=1 build, r0 read addr 0x01 returning 0xC3
//    -> r0_ack at t+2 with r0_rd = 0xC3; back-to-back spacing of 3 cycles.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   One requester port of the memory-port arbiter. A requester raises req with
//   we/addr/wd held stable. The arbiter answers with a one-cycle ack. On a
//   read, rd carries the data in the ack cycle and keeps it until the next
//   read on this port.
//
//   Signals (N = address/data width)
//     req   requester -> arbiter  1  request, held until ack
//     we    requester -> arbiter  1  write (1) / read (0)
//     addr  requester -> arbiter  N  address
//     wd    requester -> arbiter  N  write data
//     rd    arbiter -> requester  N  read data
//     ack   arbiter -> requester  1  one-cycle completion pulse
//
//   Modports
//     master  requester side
//     slave   arbiter side
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int N = 8
);
  logic         req;
  logic         we;
  logic [N-1:0] addr;
  logic [N-1:0] wd;
  logic [N-1:0] rd;
  logic         ack;

  modport master (output req, output we, output addr, output wd,
                  input  rd,  input  ack);
  modport slave  (input  req, input  we, input  addr, input  wd,
                  output rd,  output ack);
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one external memory port between two requesters:
//     r0 : cache line refill / writeback
//     r1 : debug / JTAG memory access
//   The arbiter is round-robin and keeps one transaction in flight. Memory
//   latency is fixed at MEM_LAT cycles.
//
//   Sequence: IDLE -> ACCESS (MEM_LAT cycles) -> DONE -> IDLE.
//   An ack arrives MEM_LAT+1 cycles after the request is sampled.
//
//   Parameters
//     N        address / data width
//     MEM_LAT  cycles from address valid to mem_rd valid (must be >= 1)
//
//   Ports
//     CLK     in   rising-edge clock
//     RESET   in   synchronous, active-high reset
//     r0, r1  if   requester ports (slave modport)
//     mem_a   out  registered memory address
//     mem_wd  out  registered memory write data
//     mem_we  out  registered write enable, high only in the first ACCESS cycle
//     mem_rd  in   memory read data
//     busy    out  high whenever the arbiter is not IDLE
//     owner   out  index of the most recently granted port
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int N       = 8,
  parameter int MEM_LAT = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  mem_port_arbiter_if.slave r0,
  mem_port_arbiter_if.slave r1,
  output logic [N-1:0]   mem_a,
  output logic [N-1:0]   mem_wd,
  output logic           mem_we,
  input  logic [N-1:0]   mem_rd,
  output logic           busy,
  output logic           owner
);

  // A zero latency would leave no cycle in which the address is valid before
  // the data is captured, so reject it when the design is built.
  if (MEM_LAT < 1) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end

  localparam int LAT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]       state;
  logic [LAT_W-1:0] lat_cnt;
  logic             last;     // port granted most recently; its opposite wins a tie
  logic             xfer_we;  // type of the transaction in flight (mem_we only lasts one cycle)
  logic             grant;

  // NOTE: every signal written in always_comb gets a default value first.
  // Without it, a path that leaves the signal unassigned infers a latch.
  always_comb begin
    grant = 1'b0;
    if (r0.req && r1.req) begin
      grant = ~last;
    end else if (r1.req) begin
      grant = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register reads the values from before the clock edge. Reset is synchronous:
  // it is sampled on the rising edge like any other input. It also clears the
  // read-data registers, so every output is 0 after reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      lat_cnt <= '0;
      last    <= 1'b1;
      xfer_we <= 1'b0;
      owner   <= 1'b0;
      mem_a   <= '0;
      mem_wd  <= '0;
      mem_we  <= 1'b0;
      r0.rd   <= '0;
      r1.rd   <= '0;
      r0.ack  <= 1'b0;
      r1.ack  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (r0.req || r1.req) begin
            mem_a   <= grant ? r1.addr : r0.addr;
            mem_wd  <= grant ? r1.wd   : r0.wd;
            mem_we  <= grant ? r1.we   : r0.we;
            xfer_we <= grant ? r1.we   : r0.we;
            owner   <= grant;
            last    <= grant;
            lat_cnt <= LAT_W'(MEM_LAT - 1);
            state   <= ACCESS;
          end
        end

        ACCESS: begin
          // The write strobe covers only the first ACCESS cycle. mem_a and
          // mem_wd are not touched here, so they stay stable.
          mem_we <= 1'b0;
          if (lat_cnt == '0) begin
            if (!xfer_we) begin
              if (owner) r1.rd <= mem_rd;
              else       r0.rd <= mem_rd;
            end
            if (owner) r1.ack <= 1'b1;
            else       r0.ack <= 1'b1;
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end

        DONE: begin
          // A req still high here belongs to the transaction that just
          // finished, so DONE does not sample it.
          r0.ack <= 1'b0;
          r1.ack <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. dut_a is built with MEM_LAT=2 and
//   dut_b with MEM_LAT=1. Each memory is modelled as a fixed function of the
//   address:
//     dut_a : rd = addr ^ 8'h4A   (0x10 -> 0x5A)
//     dut_b : rd = addr ^ 8'hC2   (0x01 -> 0xC3)
//   Inputs change 1 time unit after a rising edge. Outputs are sampled at
//   the same point.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic       CLK;
  logic       RESET;

  mem_port_arbiter_if #(.N(8)) a0 ();
  mem_port_arbiter_if #(.N(8)) a1 ();
  mem_port_arbiter_if #(.N(8)) b0 ();
  mem_port_arbiter_if #(.N(8)) b1 ();

  logic [7:0] a_mem_a, a_mem_wd, a_mem_rd;
  logic       a_mem_we, a_busy, a_owner;
  logic [7:0] b_mem_a, b_mem_wd, b_mem_rd;
  logic       b_mem_we, b_busy, b_owner;

  assign a_mem_rd = a_mem_a ^ 8'h4A;
  assign b_mem_rd = b_mem_a ^ 8'hC2;

  mem_port_arbiter #(.N(8), .MEM_LAT(2)) dut_a (
    .CLK    (CLK),
    .RESET  (RESET),
    .r0     (a0),
    .r1     (a1),
    .mem_a  (a_mem_a),
    .mem_wd (a_mem_wd),
    .mem_we (a_mem_we),
    .mem_rd (a_mem_rd),
    .busy   (a_busy),
    .owner  (a_owner)
  );

  mem_port_arbiter #(.N(8), .MEM_LAT(1)) dut_b (
    .CLK    (CLK),
    .RESET  (RESET),
    .r0     (b0),
    .r1     (b1),
    .mem_a  (b_mem_a),
    .mem_wd (b_mem_wd),
    .mem_we (b_mem_we),
    .mem_rd (b_mem_rd),
    .busy   (b_busy),
    .owner  (b_owner)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  time t_prev;
  logic exp_owner;

  initial begin
    RESET   = 1'b1;
    a0.req  = 1'b0; a0.we = 1'b0; a0.addr = 8'h00; a0.wd = 8'h00;
    a1.req  = 1'b0; a1.we = 1'b0; a1.addr = 8'h00; a1.wd = 8'h00;
    b0.req  = 1'b0; b0.we = 1'b0; b0.addr = 8'h00; b0.wd = 8'h00;
    b1.req  = 1'b0; b1.we = 1'b0; b1.addr = 8'h00; b1.wd = 8'h00;
    tick();
    tick();

    // ---- Reset values -----------------------------------------------------
    chk("rst_mem_a",  32'(a_mem_a),  32'h0);
    chk("rst_mem_wd", 32'(a_mem_wd), 32'h0);
    chk("rst_mem_we", 32'(a_mem_we), 32'h0);
    chk("rst_busy",   32'(a_busy),   32'h0);
    chk("rst_owner",  32'(a_owner),  32'h0);
    chk("rst_r0_ack", 32'(a0.ack),   32'h0);
    chk("rst_r1_ack", 32'(a1.ack),   32'h0);
    chk("rst_r0_rd",  32'(a0.rd),    32'h0);
    chk("rst_r1_rd",  32'(a1.rd),    32'h0);
    chk("rst_b_busy", 32'(b_busy),   32'h0);
    RESET = 1'b0;
    tick();

    // ---- Test 1: r0 read 0x10 -> 0x5A, ack at t+3 -------------------------
    a0.req = 1'b1; a0.we = 1'b0; a0.addr = 8'h10;
    tick();                                             // t+1
    chk("t1_busy",     32'(a_busy),   32'h1);
    chk("t1_owner",    32'(a_owner),  32'h0);
    chk("t1_mem_a",    32'(a_mem_a),  32'h10);
    chk("t1_mem_we_1", 32'(a_mem_we), 32'h0);
    chk("t1_ack_early1", 32'(a0.ack), 32'h0);
    tick();                                             // t+2
    chk("t1_mem_we_2", 32'(a_mem_we), 32'h0);
    chk("t1_mem_a_2",  32'(a_mem_a),  32'h10);
    chk("t1_ack_early2", 32'(a0.ack), 32'h0);
    tick();                                             // t+3
    chk("t1_r0_ack",   32'(a0.ack),   32'h1);
    chk("t1_r0_rd",    32'(a0.rd),    32'h5A);
    chk("t1_r1_ack",   32'(a1.ack),   32'h0);
    chk("t1_mem_we_3", 32'(a_mem_we), 32'h0);
    a0.req = 1'b0;
    tick();                                             // t+4
    chk("t1_idle",     32'(a_busy),   32'h0);
    chk("t1_ack_drop", 32'(a0.ack),   32'h0);
    chk("t1_rd_hold",  32'(a0.rd),    32'h5A);

    // ---- Test 2: r1 write 0x22 <- 0x7E ------------------------------------
    a1.req = 1'b1; a1.we = 1'b1; a1.addr = 8'h22; a1.wd = 8'h7E;
    tick();                                             // t+1
    chk("t2_mem_we_1", 32'(a_mem_we), 32'h1);
    chk("t2_mem_a",    32'(a_mem_a),  32'h22);
    chk("t2_mem_wd",   32'(a_mem_wd), 32'h7E);
    chk("t2_owner",    32'(a_owner),  32'h1);
    tick();                                             // t+2
    chk("t2_mem_we_2", 32'(a_mem_we), 32'h0);
    chk("t2_mem_a_2",  32'(a_mem_a),  32'h22);
    tick();                                             // t+3
    chk("t2_r1_ack",   32'(a1.ack),   32'h1);
    chk("t2_r0_ack",   32'(a0.ack),   32'h0);
    chk("t2_r1_rd",    32'(a1.rd),    32'h0);
    chk("t2_mem_we_3", 32'(a_mem_we), 32'h0);
    a1.req = 1'b0;
    tick();
    chk("t2_idle",     32'(a_busy),   32'h0);
    chk("t2_r0_rd",    32'(a0.rd),    32'h5A);

    // ---- Test 3: simultaneous requests straight after reset ---------------
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    a0.req = 1'b1; a0.we = 1'b0; a0.addr = 8'h30;       // expect 0x7A
    a1.req = 1'b1; a1.we = 1'b0; a1.addr = 8'h44;       // expect 0x0E
    tick();                                             // t+1
    chk("t3_owner_0",  32'(a_owner),  32'h0);
    chk("t3_mem_a_0",  32'(a_mem_a),  32'h30);
    tick();                                             // t+2
    tick();                                             // t+3
    chk("t3_r0_ack",   32'(a0.ack),   32'h1);
    chk("t3_r1_ack_0", 32'(a1.ack),   32'h0);
    chk("t3_r0_rd",    32'(a0.rd),    32'h7A);
    a0.req = 1'b0;
    tick();                                             // t+4: r1 granted
    chk("t3_idle",     32'(a_busy),   32'h0);
    tick();                                             // t+5
    chk("t3_owner_1",  32'(a_owner),  32'h1);
    chk("t3_mem_a_1",  32'(a_mem_a),  32'h44);
    tick();                                             // t+6
    tick();                                             // t+7
    chk("t3_r1_ack",   32'(a1.ack),   32'h1);
    chk("t3_r0_ack_1", 32'(a0.ack),   32'h0);
    chk("t3_r1_rd",    32'(a1.rd),    32'h0E);
    chk("t3_r0_rd_keep", 32'(a0.rd),  32'h7A);
    a1.req = 1'b0;
    tick();

    // ---- Test 4: both always requesting, 6 transactions -------------------
    // last = 1 after test 3, so port 0 is granted first.
    a0.req = 1'b1; a0.we = 1'b0; a0.addr = 8'h55;
    a1.req = 1'b1; a1.we = 1'b0; a1.addr = 8'h66;
    t_prev = 0;
    for (int k = 0; k < 6; k++) begin
      exp_owner = k[0];
      tick();                                           // ACCESS 1
      chk($sformatf("t4_owner_%0d", k), 32'(a_owner), 32'(exp_owner));
      chk($sformatf("t4_mem_a_%0d", k), 32'(a_mem_a), exp_owner ? 32'h66 : 32'h55);
      tick();                                           // ACCESS 2
      tick();                                           // DONE
      chk($sformatf("t4_ack0_%0d", k), 32'(a0.ack), 32'(!exp_owner));
      chk($sformatf("t4_ack1_%0d", k), 32'(a1.ack), 32'(exp_owner));
      if (k > 0) begin
        chk($sformatf("t4_spacing_%0d", k), 32'($time - t_prev), 32'd40);
      end
      t_prev = $time;
      tick();                                           // IDLE, next grant
    end
    a0.req = 1'b0;
    a1.req = 1'b0;
    chk("t4_r0_rd", 32'(a0.rd), 32'h1F);                // 0x55 ^ 0x4A
    chk("t4_r1_rd", 32'(a1.rd), 32'h2C);                // 0x66 ^ 0x4A
    tick();
    tick();
    chk("t4_idle", 32'(a_busy), 32'h0);

    // ---- Test 5: reset in the second ACCESS cycle of an r0 write ----------
    a0.req = 1'b1; a0.we = 1'b1; a0.addr = 8'h66; a0.wd = 8'h99;
    tick();                                             // ACCESS 1
    chk("t5_mem_we_1", 32'(a_mem_we), 32'h1);
    tick();                                             // ACCESS 2
    RESET = 1'b1;
    tick();
    chk("t5_rst_busy",   32'(a_busy),   32'h0);
    chk("t5_rst_mem_we", 32'(a_mem_we), 32'h0);
    chk("t5_rst_ack",    32'(a0.ack),   32'h0);
    chk("t5_rst_mem_a",  32'(a_mem_a),  32'h0);
    RESET = 1'b0;                                       // req still high: reissued
    tick();                                             // t+1
    chk("t5_no_ack",     32'(a0.ack),   32'h0);
    chk("t5_mem_we_r",   32'(a_mem_we), 32'h1);
    chk("t5_mem_a_r",    32'(a_mem_a),  32'h66);
    chk("t5_mem_wd_r",   32'(a_mem_wd), 32'h99);
    tick();                                             // t+2
    tick();                                             // t+3
    chk("t5_ack",        32'(a0.ack),   32'h1);
    chk("t5_rd_unch",    32'(a0.rd),    32'h0);
    a0.req = 1'b0;
    tick();

    // ---- Test 6: MEM_LAT=1, r0 read 0x01 -> 0xC3, back-to-back -----------
    b0.req = 1'b1; b0.we = 1'b0; b0.addr = 8'h01;
    tick();                                             // t+1
    chk("t6_busy",     32'(b_busy),   32'h1);
    chk("t6_mem_a",    32'(b_mem_a),  32'h01);
    chk("t6_ack_early", 32'(b0.ack),  32'h0);
    tick();                                             // t+2
    chk("t6_ack",      32'(b0.ack),   32'h1);
    chk("t6_rd",       32'(b0.rd),    32'hC3);
    chk("t6_r1_ack",   32'(b1.ack),   32'h0);
    t_prev = $time;
    tick();                                             // IDLE, regrant
    chk("t6_ack_drop", 32'(b0.ack),   32'h0);
    tick();                                             // ACCESS
    tick();                                             // DONE
    chk("t6_ack2",     32'(b0.ack),   32'h1);
    chk("t6_spacing",  32'($time - t_prev), 32'd30);
    b0.req = 1'b0;
    tick();
    chk("t6_idle",     32'(b_busy),   32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
